// File: rtl/spi_master_ctrl_if.sv
// CPU register bus and SPI pins of the SPI master controller.
// The slave modport is used by the controller, which is a slave on the CPU bus.
// The master modport is used by whatever drives that bus.
interface spi_master_ctrl_if;
    logic [15:0] addr;
    logic [7:0]  wrData;
    logic        ioWr;
    logic        ioRd;
    logic [7:0]  rdData;
    logic        SPI_CLK;
    logic        SPI_MOSI;
    logic        SPI_MISO;
    logic [5:0]  SPI_CS;
    logic        busy;

    modport slave (
        input  addr, wrData, ioWr, ioRd, SPI_MISO,
        output rdData, SPI_CLK, SPI_MOSI, SPI_CS, busy
    );

    modport master (
        output addr, wrData, ioWr, ioRd, SPI_MISO,
        input  rdData, SPI_CLK, SPI_MOSI, SPI_CS, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master with CPU-mapped DATA, SS and MODE/STATUS registers.
// Supports all four CPOL/CPHA modes, MSB- or LSB-first bit order, and a
// half-period of 1, 2, 4 or 8 clk cycles.
module spi_master_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0F06
) (
    input  logic             clk,
    input  logic             reset,
    spi_master_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_mode;      // {sel[1:0], lsb_first, cpol, cpha}
    logic [5:0]  r_ss;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_rx_data;
    logic [2:0]  r_half;
    logic [3:0]  r_edge;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_busy;
    logic        r_done;
    logic        r_ovr;

    logic        w_sel_data, w_sel_ss, w_sel_mode;
    logic        w_wr_data, w_wr_ss, w_wr_mode, w_rd_data;
    logic        w_cpha, w_cpol, w_lsb;
    logic        w_leading, w_expire, w_sample, w_shift;
    logic [2:0]  w_half_last;
    logic [7:0]  w_rd_mux;

    assign w_sel_data = (bus.addr == BASE_ADDR);
    assign w_sel_ss   = (bus.addr == BASE_ADDR + 16'd1);
    assign w_sel_mode = (bus.addr == BASE_ADDR + 16'd2);

    assign w_wr_data  = bus.ioWr & w_sel_data;
    assign w_wr_ss    = bus.ioWr & w_sel_ss;
    assign w_wr_mode  = bus.ioWr & w_sel_mode;
    assign w_rd_data  = bus.ioRd & w_sel_data;

    assign w_cpha     = r_mode[0];
    assign w_cpol     = r_mode[1];
    assign w_lsb      = r_mode[2];

    // Even edge numbers are leading edges, odd ones trailing edges.
    assign w_leading  = ~r_edge[0];
    assign w_expire   = (r_half == w_half_last);
    // CPHA=0 samples on leading and shifts on trailing; CPHA=1 the reverse.
    // Edge 15 never shifts: the eighth bit is the last one driven.
    assign w_sample   = w_leading ^ w_cpha;
    assign w_shift    = ~(w_leading ^ w_cpha) & (r_edge != 4'd15);

    // Terminal count of the half-period counter: H-1 with H = 2^sel.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_half_last = 3'd0;
        case (r_mode[4:3])
            2'd0:    w_half_last = 3'd0;
            2'd1:    w_half_last = 3'd1;
            2'd2:    w_half_last = 3'd3;
            default: w_half_last = 3'd7;
        endcase
    end

    // Combinational register read-back; unmapped addresses read as zero.
    always_comb begin
        w_rd_mux = 8'h00;
        if (w_sel_data)
            w_rd_mux = r_rx_data;
        else if (w_sel_ss)
            w_rd_mux = {2'b00, r_ss};
        else if (w_sel_mode)
            w_rd_mux = {r_busy, r_done, r_ovr, r_mode};
    end

    function automatic logic first_bit(input logic [7:0] d, input logic lsb);
        return lsb ? d[0] : d[7];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] d, input logic lsb);
        return lsb ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] d, input logic b,
                                            input logic lsb);
        return lsb ? {b, d[7:1]} : {d[6:0], b};
    endfunction

    // Transfer FSM together with the CPU-visible registers it guards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 5'h00;
            r_ss      <= 6'h3F;
            r_tx      <= 8'h00;
            r_rx_sh   <= 8'h00;
            r_rx_data <= 8'h00;
            r_half    <= 3'd0;
            r_edge    <= 4'd0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // right-hand side sees pre-edge values; this also lets the later
            // flag sets below override the read-clear without a race.
            if (w_rd_data) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_sclk <= w_cpol;
                    r_half <= 3'd0;
                    r_edge <= 4'd0;
                    if (w_wr_ss)
                        r_ss <= bus.wrData[5:0];
                    if (w_wr_mode)
                        r_mode <= bus.wrData[4:0];
                    if (w_wr_data) begin
                        r_state <= S_XFER;
                        r_busy  <= 1'b1;
                        if (!w_cpha) begin
                            r_mosi <= first_bit(bus.wrData, w_lsb);
                            r_tx   <= shift_out(bus.wrData, w_lsb);
                        end else begin
                            r_tx   <= bus.wrData;
                        end
                    end
                end

                S_XFER: begin
                    if (w_wr_data)
                        r_ovr <= 1'b1;
                    if (w_expire) begin
                        r_half <= 3'd0;
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 4'd1;
                        if (w_sample)
                            r_rx_sh <= shift_in(r_rx_sh, bus.SPI_MISO, w_lsb);
                        if (w_shift) begin
                            r_mosi <= first_bit(r_tx, w_lsb);
                            r_tx   <= shift_out(r_tx, w_lsb);
                        end
                        if (r_edge == 4'd15)
                            r_state <= S_DONE;
                    end else begin
                        r_half <= r_half + 3'd1;
                    end
                end

                default: begin
                    if (w_wr_data)
                        r_ovr <= 1'b1;
                    r_rx_data <= r_rx_sh;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_sclk    <= w_cpol;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdData   = w_rd_mux;
    assign bus.SPI_CLK  = r_sclk;
    assign bus.SPI_MOSI = r_mosi;
    assign bus.SPI_CS   = r_ss;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a table of register accesses,
// then hand-written transfer sequences for the multi-cycle corner cases.
module tb_spi_master_ctrl;

    localparam logic [15:0] BASE  = 16'h0F06;
    localparam logic [15:0] A_DAT = BASE;
    localparam logic [15:0] A_SS  = BASE + 16'd1;
    localparam logic [15:0] A_MOD = BASE + 16'd2;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic [5:0]  exp_cs;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    int   cyc;
    int   t0;
    int   elapsed;
    int   cap_start;
    int   cap_total;
    logic [7:0] cap_byte;
    logic loopback;
    logic slave_miso;
    logic [7:0] slv;
    vec_t vecs[15];

    spi_master_ctrl_if bus();

    spi_master_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.SPI_MISO = loopback ? bus.SPI_MOSI : slave_miso;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log of MOSI at every rising SPI_CLK during a transfer (leading edge in mode 0).
    initial begin
        cap_total = 0;
        cap_byte  = 8'h00;
    end
    always @(posedge bus.SPI_CLK) begin
        if (bus.busy) begin
            cap_byte  = {cap_byte[6:0], bus.SPI_MOSI};
            cap_total = cap_total + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr   = a;
        bus.wrData = d;
        bus.ioWr   = 1'b1;
        @(negedge clk);
        bus.ioWr   = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.addr = a;
        bus.ioRd = 1'b1;
        #1 check(name, bus.rdData, exp);
        @(negedge clk);
        bus.ioRd = 1'b0;
    endtask

    // Polls the done flag through STATUS (no read strobe, so it is not cleared).
    task automatic wait_done(input string name, input int start, input int limit,
                             output int el);
        logic prev_busy;
        logic seen;
        bus.addr  = A_MOD;
        prev_busy = bus.busy;
        seen      = 1'b0;
        el        = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (bus.rdData[6]) begin
                seen = 1'b1;
                el   = cyc - start;
                break;
            end
            prev_busy = bus.busy;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        if (seen)
            check({name, "_busy_falls_with_done"}, {prev_busy, bus.busy}, 2'b10);
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        loopback   = 1'b1;
        slave_miso = 1'b0;
        bus.addr   = 16'h0000;
        bus.wrData = 8'h00;
        bus.ioWr   = 1'b0;
        bus.ioRd   = 1'b0;
        reset      = 1'b1;

        //                 wr    rd    addr      wdata  exp_rd exp_cs
        vecs[0]  = '{1'b0, 1'b1, A_DAT,    8'h00, 8'h00, 6'h3F};
        vecs[1]  = '{1'b0, 1'b1, A_SS,     8'h00, 8'h3F, 6'h3F};
        vecs[2]  = '{1'b0, 1'b1, A_MOD,    8'h00, 8'h00, 6'h3F};
        vecs[3]  = '{1'b0, 1'b1, 16'h0F05, 8'h00, 8'h00, 6'h3F};
        vecs[4]  = '{1'b0, 1'b1, 16'h0F09, 8'h00, 8'h00, 6'h3F};
        vecs[5]  = '{1'b1, 1'b0, A_SS,     8'h3E, 8'h00, 6'h3E};
        vecs[6]  = '{1'b0, 1'b1, A_SS,     8'h00, 8'h3E, 6'h3E};
        vecs[7]  = '{1'b1, 1'b0, A_MOD,    8'hFF, 8'h00, 6'h3E};
        vecs[8]  = '{1'b0, 1'b1, A_MOD,    8'h00, 8'h1F, 6'h3E};
        vecs[9]  = '{1'b1, 1'b0, A_MOD,    8'h00, 8'h00, 6'h3E};
        vecs[10] = '{1'b0, 1'b1, A_MOD,    8'h00, 8'h00, 6'h3E};
        vecs[11] = '{1'b1, 1'b0, A_SS,     8'hC5, 8'h00, 6'h05};
        vecs[12] = '{1'b0, 1'b1, A_SS,     8'h00, 8'h05, 6'h05};
        vecs[13] = '{1'b1, 1'b1, A_SS,     8'h3E, 8'h05, 6'h3E};
        vecs[14] = '{1'b0, 1'b1, A_SS,     8'h00, 8'h3E, 6'h3E};

        repeat (3) @(negedge clk);
        #1;
        check("reset_spi_clk", bus.SPI_CLK, 1'b0);
        check("reset_mosi", bus.SPI_MOSI, 1'b0);
        check("reset_cs", bus.SPI_CS, 6'h3F);
        check("reset_busy", bus.busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Register access table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.addr   = vecs[i].addr;
            bus.wrData = vecs[i].wdata;
            bus.ioWr   = vecs[i].wr;
            bus.ioRd   = vecs[i].rd;
            #1;
            if (vecs[i].rd)
                check($sformatf("vec%0d_rd", i), bus.rdData, vecs[i].exp_rd);
            @(negedge clk);
            bus.ioWr = 1'b0;
            bus.ioRd = 1'b0;
            check($sformatf("vec%0d_cs", i), bus.SPI_CS, vecs[i].exp_cs);
        end

        // Mode 0, H=1, loopback of 8'hA5.
        check("m0_idle_busy", bus.busy, 1'b0);
        cap_start = cap_total;
        bus_write(A_DAT, 8'hA5);
        t0 = cyc;
        check("m0_busy_after_strobe", bus.busy, 1'b1);
        check("m0_cs", bus.SPI_CS, 6'h3E);
        wait_done("m0", t0, 60, elapsed);
        check("m0_done_latency", elapsed, 17);
        check("m0_sclk_edges", cap_total - cap_start, 8);
        check("m0_mosi_bits", cap_byte, 8'hA5);
        bus_read("m0_rx", A_DAT, 8'hA5);
        bus_read("m0_status_cleared", A_MOD, 8'h00);

        // CPHA=1, CPOL=1, H=8, slave drives 8'h3C on each leading (falling) edge.
        loopback = 1'b0;
        slv      = 8'h3C;
        bus_write(A_MOD, 8'h1B);
        @(negedge clk);
        check("m3_sclk_idle_high", bus.SPI_CLK, 1'b1);
        bus_write(A_DAT, 8'h00);
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge bus.SPI_CLK);
            slave_miso = slv[3'(7 - i)];
        end
        wait_done("m3", t0, 60, elapsed);
        check("m3_done_latency", elapsed, 129);
        check("m3_sclk_after_done", bus.SPI_CLK, 1'b1);
        bus_read("m3_rx", A_DAT, 8'h3C);
        loopback = 1'b1;

        // LSB-first, H=1, data 8'h01.
        bus_write(A_MOD, 8'h04);
        cap_start = cap_total;
        bus_write(A_DAT, 8'h01);
        t0 = cyc;
        wait_done("lsb", t0, 60, elapsed);
        check("lsb_mosi_order", cap_byte, 8'h80);
        check("lsb_sclk_edges", cap_total - cap_start, 8);
        bus_read("lsb_rx", A_DAT, 8'h01);

        // Overrun and ignored register writes during a transfer.
        bus_write(A_MOD, 8'h00);
        cap_start = cap_total;
        bus_write(A_DAT, 8'hAA);
        t0 = cyc;
        bus_write(A_DAT, 8'h55);
        bus_write(A_MOD, 8'h1B);
        bus_write(A_SS, 8'h00);
        check("ovr_cs_unchanged_live", bus.SPI_CS, 6'h3E);
        wait_done("ovr", t0, 60, elapsed);
        check("ovr_mosi_only_first", cap_byte, 8'hAA);
        check("ovr_sclk_edges", cap_total - cap_start, 8);
        bus_read("ovr_status", A_MOD, 8'h60);
        bus_read("ovr_ss_kept", A_SS, 8'h3E);
        bus_read("ovr_rx", A_DAT, 8'hAA);
        bus_read("ovr_cleared_mode_kept", A_MOD, 8'h00);

        // Reset asserted around edge 5 of a transfer.
        bus_write(A_DAT, 8'hF0);
        repeat (6) @(negedge clk);
        check("rst_busy_before", bus.busy, 1'b1);
        #1 reset = 1'b1;
        #2;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cs", bus.SPI_CS, 6'h3F);
        check("rst_sclk", bus.SPI_CLK, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus_read("rst_status", A_MOD, 8'h00);
        bus_read("rst_rx", A_DAT, 8'h00);
        bus_write(A_SS, 8'h3E);
        bus_write(A_DAT, 8'h3C);
        t0 = cyc;
        wait_done("rst_again", t0, 60, elapsed);
        check("rst_again_latency", elapsed, 17);
        bus_read("rst_again_rx", A_DAT, 8'h3C);

        // DATA read in the DONE cycle: returns old byte, done still set.
        bus_write(A_DAT, 8'h96);
        repeat (16) @(negedge clk);
        check("dn_busy_in_done", bus.busy, 1'b1);
        bus.addr = A_DAT;
        bus.ioRd = 1'b1;
        #1 check("dn_old_rx", bus.rdData, 8'h3C);
        @(negedge clk);
        bus.ioRd = 1'b0;
        bus.addr = A_MOD;
        #1 check("dn_done_wins", bus.rdData, 8'h40);
        bus_read("dn_new_rx", A_DAT, 8'h96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0F06: I/O base; DATA=BASE, SS=BASE+1, MODE/STATUS=BASE+2.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 addr  input  16  CPU address, qualified by ioRd/ioWr.
REQ-005 wrData  input  8  CPU write data.
REQ-006 ioWr  input  1  one-cycle write strobe, clk domain.
REQ-007 ioRd  input  1  one-cycle read strobe, clk domain.
REQ-008 rdData  output  8  combinational read data for addr; 8'h00 when addr is not one of the three registers.
REQ-009 SPI_CLK  output  1  serial clock.
REQ-010 SPI_MOSI  output  1  serial data out.
REQ-011 SPI_MISO  input  1  serial data in.
REQ-012 SPI_CS  output  6  active-low chip selects, driven directly from the SS register.
REQ-013 busy  output  1  transfer in progress.

Function
REQ-014 MODE write: bit0 = CPHA, bit1 = CPOL, bit2 = LSB-first, bits[4:3] = sel; bits[7:5] ignored; half-period H = 2^sel clk cycles (1..8).
REQ-015 MODE/STATUS read SHALL return {busy, done, ovr, mode[4:0]}.
REQ-016 SS write SHALL load ssReg[5:0] = wrData[5:0]; SPI_CS = ssReg; SS read SHALL return {2'b00, ssReg}.
REQ-017 Writes to SS or MODE while busy=1 SHALL be ignored.
REQ-018 DATA write while IDLE SHALL latch wrData into txShift, enter XFER on the next edge, and set busy=1 one cycle after the strobe.
REQ-019 DATA write while busy=1 SHALL be ignored and SHALL set ovr=1.
REQ-020 DATA read SHALL return rxData and clear done and ovr; if done sets in the same cycle, set wins.
REQ-021 States: IDLE -> XFER (DATA write) -> DONE (after 16th half-period) -> IDLE (unconditional, 1 cycle).
REQ-022 XFER: a half-period counter counts H cycles; at each expiry, SPI_CLK toggles and the edge counter e (0..15) increments; even e = leading edge, odd e = trailing edge.
REQ-023 CPHA=0: the first bit is on SPI_MOSI on XFER entry; MISO is sampled on the leading edge; the next bit shifts out on the trailing edge (none after the 8th).
REQ-024 CPHA=1: a bit shifts out on the leading edge; MISO is sampled on the trailing edge.
REQ-025 Bit order: MSB first unless LSB-first=1; the receive shift direction matches the transmit direction.
REQ-026 DONE: rxData <= assembled byte; done=1; busy=0 in the same cycle; SPI_CLK = CPOL.
REQ-027 Transfer length: the DATA write strobe is at cycle T; done=1 and busy=0 are visible at cycle T+1+16*H+1.
REQ-028 Idle: SPI_CLK = CPOL; SPI_MOSI holds its last driven value.
REQ-029 ioRd and ioWr in the same cycle: both processed (write takes effect next cycle; read returns pre-write contents).
REQ-030 No internal MISO synchronizer; MISO is sampled directly at the sample edge (the source is synchronous to SPI_CLK).

Reset
REQ-031 With reset=1 (asynchronous), the state is IDLE and: SPI_CLK=0, SPI_MOSI=0, SPI_CS=6'h3F, busy=0, done=0, ovr=0, mode=5'h00, rxData=8'h00, edge and half-period counters=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately: no DONE, no rxData update, SPI_CS returns to 6'h3F.

Verification
REQ-033 Mode 0, sel=0, SS=6'h3E, DATA write 8'hA5, MISO loopback -> SPI_CS[0] low; MOSI sequence 1,0,1,0,0,1,0,1; 8 rising SPI_CLK edges; done at T+18; DATA read = 8'hA5.
REQ-034 MODE=5'h1B (CPHA=1, CPOL=1, sel=3), MISO slave byte 8'h3C -> SPI_CLK idles high; H=8; done at T+130; rxData = 8'h3C.
REQ-035 LSB-first (MODE=5'h04), DATA write 8'h01 -> MOSI first bit 1, then seven 0s.
REQ-036 Second DATA write 8'h55 during a transfer of 8'hAA -> ovr=1; MOSI carries only 8'hAA; writes to MODE and SS during the transfer leave both registers unchanged.
REQ-037 Reset pulse at edge 5 of a transfer -> busy=0, SPI_CS=6'h3F, done=0, rxData=8'h00; a new DATA write afterwards completes normally.
REQ-038 DATA read in the same cycle as DONE -> done=1 afterward; the read returns the old rxData.
